// File: rtl/pio_bank.sv
// Parallel I/O bank: output registers, synchronised inputs with rising-edge capture,
// per-bit interrupt mask and a registered read port. Define PIO_BANK_DEBOUNCE_EN to add input debouncers.
module pio_bank #(
  parameter int DATA_W    = 32,
  parameter int N_IN      = 2,
  parameter int N_OUT     = 4,
  parameter int DEB_LIMIT = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_W-1:0]       writedata,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    irq,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port
);

  typedef enum logic [1:0] {
    GRP_OUT  = 2'd0,
    GRP_IN   = 2'd1,
    GRP_EDGE = 2'd2,
    GRP_MASK = 2'd3
  } grp_e;

  if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8 ||
      DEB_LIMIT < 1 || DEB_LIMIT > 65535) begin : g_param_check
    $error("pio_bank: parameter outside legal range");
  end

  grp_e       grp;
  logic [2:0] ch;
  logic       wr_out;
  logic       wr_edge;
  logic       wr_mask;

  assign grp     = grp_e'(address[4:3]);
  assign ch      = address[2:0];
  assign wr_out  = write && (grp == GRP_OUT);
  assign wr_edge = write && (grp == GRP_EDGE);
  assign wr_mask = write && (grp == GRP_MASK);

  logic [N_OUT*DATA_W-1:0] out_q;
  logic [N_IN*DATA_W-1:0]  sync_meta;
  logic [N_IN*DATA_W-1:0]  sync_q;
  logic [N_IN*DATA_W-1:0]  stable_flat;
  logic [N_IN*DATA_W-1:0]  edge_flat;
  logic [N_IN*DATA_W-1:0]  mask_flat;

  // NOTE: sequential state uses <= only, and every channel register is cleared by the
  // asynchronous reset so no stale output, edge or mask survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
    end else if (wr_out) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (int'(ch) == k) out_q[k*DATA_W +: DATA_W] <= writedata;
      end
    end
  end

  assign out_port = out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    logic [DATA_W-1:0] sync_word;
    logic [DATA_W-1:0] stable_q;
    logic [DATA_W-1:0] stable_d;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] clr;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] mask_q;

    assign sync_word = sync_q[k*DATA_W +: DATA_W];

`ifdef PIO_BANK_DEBOUNCE_EN
    logic [15:0] deb_cnt;
    logic        deb_done;

    assign deb_done = (deb_cnt == 16'(DEB_LIMIT - 1));

    // Counts consecutive cycles the synchronised word disagrees with the accepted word.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_cnt <= '0;
      end else if (sync_word == stable_q || deb_done) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end

    assign stable_d = (sync_word != stable_q && deb_done) ? sync_word : stable_q;
`else
    assign stable_d = sync_word;
`endif

    assign rise = stable_d & ~stable_q;
    assign clr  = (wr_edge && int'(ch) == k) ? writedata : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stable_q <= '0;
        edge_q   <= '0;
        mask_q   <= '0;
      end else begin
        stable_q <= stable_d;
        // A rise landing in the same cycle as a clear keeps the bit set.
        edge_q   <= (edge_q & ~clr) | rise;
        if (wr_mask && int'(ch) == k) mask_q <= writedata;
      end
    end

    assign stable_flat[k*DATA_W +: DATA_W] = stable_q;
    assign edge_flat[k*DATA_W +: DATA_W]   = edge_q;
    assign mask_flat[k*DATA_W +: DATA_W]   = mask_q;
  end

  logic [DATA_W-1:0] rd_value;

  // NOTE: rd_value gets its default first so every path assigns it and no latch appears.
  always_comb begin
    rd_value = '0;
    case (grp)
      GRP_OUT:
        for (int k = 0; k < N_OUT; k++)
          if (int'(ch) == k) rd_value = out_q[k*DATA_W +: DATA_W];
      GRP_IN:
        for (int k = 0; k < N_IN; k++)
          if (int'(ch) == k) rd_value = stable_flat[k*DATA_W +: DATA_W];
      GRP_EDGE:
        for (int k = 0; k < N_IN; k++)
          if (int'(ch) == k) rd_value = edge_flat[k*DATA_W +: DATA_W];
      GRP_MASK:
        for (int k = 0; k < N_IN; k++)
          if (int'(ch) == k) rd_value = mask_flat[k*DATA_W +: DATA_W];
      default: rd_value = '0;
    endcase
  end

  // Read data comes from the current registers, so a same-cycle write is seen only afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      irq           <= 1'b0;
    end else begin
      readdatavalid <= read;
      readdata      <= read ? rd_value : '0;
      irq           <= |(edge_flat & mask_flat);
    end
  end

endmodule

// File: tb/tb_pio_bank.sv
// Randomised and directed bench for pio_bank, checked against a per-register behavioural model.
module tb_pio_bank;

  localparam int DW     = 32;
  localparam int N_IN   = 2;
  localparam int N_OUT  = 4;
  localparam int DEB    = 4;
`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int LAT    = 2 + DEB;
`else
  localparam int LAT    = 3;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [4:0]            address = '0;
  logic                  read = 1'b0;
  logic                  write = 1'b0;
  logic [DW-1:0]         writedata = '0;
  logic [DW-1:0]         readdata;
  logic                  readdatavalid;
  logic                  irq;
  logic [N_IN*DW-1:0]    in_port = '0;
  logic [N_OUT*DW-1:0]   out_port;

  int n_total = 0;
  int n_bad   = 0;

  pio_bank #(.DATA_W(DW), .N_IN(N_IN), .N_OUT(N_OUT), .DEB_LIMIT(DEB)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .irq(irq), .in_port(in_port), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Behavioural model: one word per register, inputs seen through a two-sample history.
  logic [DW-1:0]      m_out    [N_OUT];
  logic [DW-1:0]      m_mask   [N_IN];
  logic [DW-1:0]      m_edge   [N_IN];
  logic [DW-1:0]      m_stable [N_IN];
  int                 m_cnt    [N_IN];
  logic [DW-1:0]      m_rd;
  logic               m_rdv;
  logic               m_irq;
  logic [N_IN*DW-1:0] hist[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int g, input int c);
    case (g)
      0:       return (c < N_OUT) ? m_out[c] : '0;
      1:       return (c < N_IN) ? m_stable[c] : '0;
      2:       return (c < N_IN) ? m_edge[c] : '0;
      default: return (c < N_IN) ? m_mask[c] : '0;
    endcase
  endfunction

  function automatic logic [N_OUT*DW-1:0] model_out_flat();
    logic [N_OUT*DW-1:0] v;
    for (int k = 0; k < N_OUT; k++) v[k*DW +: DW] = m_out[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    for (int k = 0; k < N_IN; k++) begin
      m_mask[k] = '0; m_edge[k] = '0; m_stable[k] = '0; m_cnt[k] = 0;
    end
    m_rd = '0; m_rdv = 1'b0; m_irq = 1'b0;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
  endtask

  task automatic model_step();
    int g, c;
    logic [N_IN*DW-1:0] seen;
    logic [DW-1:0] sw, nst, rise, clr;
    g = int'(address[4:3]);
    c = int'(address[2:0]);
    m_rdv = read;
    m_rd  = read ? model_read(g, c) : '0;
    m_irq = 1'b0;
    for (int k = 0; k < N_IN; k++) if ((m_edge[k] & m_mask[k]) != '0) m_irq = 1'b1;
    seen = hist[1];
    for (int k = 0; k < N_IN; k++) begin
      sw = seen[k*DW +: DW];
`ifdef PIO_BANK_DEBOUNCE_EN
      nst = m_stable[k];
      if (sw == m_stable[k]) m_cnt[k] = 0;
      else begin
        m_cnt[k]++;
        if (m_cnt[k] == DEB) begin nst = sw; m_cnt[k] = 0; end
      end
`else
      nst = sw;
`endif
      rise = nst & ~m_stable[k];
      clr  = (write && g == 2 && c == k) ? writedata : '0;
      m_edge[k]   = (m_edge[k] & ~clr) | rise;
      m_stable[k] = nst;
    end
    if (write && g == 0 && c < N_OUT) m_out[c] = writedata;
    if (write && g == 3 && c < N_IN) m_mask[c] = writedata;
    hist.push_front(in_port);
    void'(hist.pop_back());
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step();
  end

  // One bus cycle: drive at a falling edge, let one rising edge pass, compare at the next fall.
  task automatic bus_cycle(input logic rd, input logic wr, input logic [4:0] a, input logic [DW-1:0] wd);
    read = rd; write = wr; address = a; writedata = wd;
    @(negedge clk);
    check("out_port", out_port, model_out_flat());
    check("readdatavalid", readdatavalid, m_rdv);
    check("readdata", readdata, m_rd);
    check("irq", irq, m_irq);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 5'd0, '0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got_irq;
    int   sh;

    #1 reset = 1'b1;
    #1;
    check("reset_out_port", out_port, '0);
    check("reset_rdv", readdatavalid, 1'b0);
    check("reset_readdata", readdata, '0);
    check("reset_irq", irq, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

`ifdef PIO_BANK_DEBOUNCE_EN
    // Two-cycle glitch followed by a steady high on ch0 bit0.
    in_port[0] = 1'b1; idle(1);
    in_port[0] = 1'b0; idle(1);
    in_port[0] = 1'b1;
    idle(LAT - 2);
    bus_cycle(1'b1, 1'b0, 5'h10, '0);
    check("glitch_no_edge", readdata, 32'h0);
    bus_cycle(1'b1, 1'b0, 5'h08, '0);
    check("deb_in_before", readdata, 32'h0);
    bus_cycle(1'b1, 1'b0, 5'h08, '0);
    check("deb_in_after", readdata, 32'h1);
`endif

    bus_cycle(1'b0, 1'b1, 5'h02, 32'hA5A5_A5A5);
    check("out_ch2", out_port[95:64], 32'hA5A5_A5A5);
    bus_cycle(1'b1, 1'b0, 5'h02, '0);
    check("rd_ch2_valid", readdatavalid, 1'b1);
    check("rd_ch2_data", readdata, 32'hA5A5_A5A5);
    bus_cycle(1'b1, 1'b1, 5'h02, 32'h1234_5678);
    check("rdwr_old_value", readdata, 32'hA5A5_A5A5);
    check("rdwr_new_out", out_port[95:64], 32'h1234_5678);
    idle(1);
    check("idle_rdv", readdatavalid, 1'b0);
    check("idle_readdata", readdata, 32'h0);

    bus_cycle(1'b1, 1'b0, 5'h0F, '0);
    check("oor_read_valid", readdatavalid, 1'b1);
    check("oor_read_data", readdata, 32'h0);
    bus_cycle(1'b0, 1'b1, 5'h07, 32'hFFFF_FFFF);
    bus_cycle(1'b0, 1'b1, 5'h08, 32'hFFFF_FFFF);
    check("oor_write_out", out_port, {32'h0, 32'h1234_5678, 64'h0});

    bus_cycle(1'b0, 1'b1, 5'h19, 32'h1);
    in_port[DW] = 1'b1;
    got_irq = 1'b0;
    for (int i = 0; i < 30 && !got_irq; i++) begin
      idle(1);
      got_irq = irq;
    end
    check("irq_on_edge", irq, 1'b1);
    bus_cycle(1'b1, 1'b0, 5'h11, '0);
    check("edge_ch1", readdata, 32'h1);
    bus_cycle(1'b0, 1'b1, 5'h11, 32'h1);
    check("irq_after_clr_1", irq, 1'b1);
    idle(1);
    check("irq_after_clr_2", irq, 1'b0);

    // Re-arm the edge bit, then clear it in the very cycle a fresh rise arrives.
    in_port[DW] = 1'b0; idle(LAT + 2);
    in_port[DW] = 1'b1; idle(LAT + 2);
    check("irq_rearmed", irq, 1'b1);
    in_port[DW] = 1'b0; idle(LAT + 2);
    check("irq_held_on_fall", irq, 1'b1);
    in_port[DW] = 1'b1;
    idle(LAT - 1);
    bus_cycle(1'b0, 1'b1, 5'h11, 32'h1);
    check("clr_vs_edge_irq", irq, 1'b1);
    bus_cycle(1'b1, 1'b0, 5'h11, '0);
    check("clr_vs_edge_bit", readdata, 32'h1);
    check("clr_vs_edge_irq2", irq, 1'b1);

    // Reset in the middle of debouncing with a read strobe pending.
    in_port[1] = 1'b1;
    bus_cycle(1'b1, 1'b0, 5'h02, '0);
    read = 1'b1; address = 5'h02;
    #2 reset = 1'b1;
    #1;
    check("rst_out_port", out_port, '0);
    check("rst_readdata", readdata, '0);
    check("rst_rdv", readdatavalid, 1'b0);
    check("rst_irq", irq, 1'b0);
    @(negedge clk);
    check("rst_no_rdv_pulse", readdatavalid, 1'b0);
    read = 1'b0;
    reset = 1'b0;

    idle(LAT);
    bus_cycle(1'b1, 1'b0, 5'h11, '0);
    check("edge_after_reset", readdata[0], 1'b1);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        sh = int'($urandom_range(0, N_IN - 1)) * DW + int'($urandom_range(0, 3));
        in_port[sh] = ~in_port[sh];
      end
      bus_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 31)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
